// File: rtl/drive_cmd_pkg.sv
// Shared constants, receiver state encoding and command decode for drive_cmd_rx.
package drive_cmd_pkg;

    localparam logic [7:0] CMD_FWD   = 8'h46;
    localparam logic [7:0] CMD_BWD   = 8'h42;
    localparam logic [7:0] CMD_LEFT  = 8'h4C;
    localparam logic [7:0] CMD_RIGHT = 8'h52;
    localparam logic [7:0] CMD_STOP  = 8'h53;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop
    } rx_state_e;

    // Direction bit order: {right, left, bwd, fwd}
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_FWD   = 4'b0001;
    localparam logic [3:0] DIR_BWD   = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef struct packed {
        logic       valid;
        logic [3:0] dir;
    } cmd_dec_t;

    function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
        cmd_dec_t d;
        d.valid = 1'b1;
        d.dir   = DIR_NONE;
        case (b)
            CMD_FWD:   d.dir = DIR_FWD;
            CMD_BWD:   d.dir = DIR_BWD;
            CMD_LEFT:  d.dir = DIR_LEFT;
            CMD_RIGHT: d.dir = DIR_RIGHT;
            CMD_STOP:  d.dir = DIR_NONE;
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/drive_cmd_rx_uart.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, 8N1 frame FSM.
// Define DRIVE_CMD_PARITY_EN for 8E1 framing with an even-parity check.
module drive_cmd_rx_uart
    import drive_cmd_pkg::*;
#(
    parameter int unsigned BIT_CYC = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err
);

    localparam int unsigned CW   = $clog2(BIT_CYC + 1);
    localparam int unsigned HALF = (BIT_CYC / 2 > 0) ? BIT_CYC / 2 : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_CYC - 1);

    rx_state_e     state;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
`ifdef DRIVE_CMD_PARITY_EN
    logic          par_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset the line history low so a line held low across reset
            // release cannot look like a fresh start edge.
            sync_q     <= 2'b00;
            prev_q     <= 1'b0;
            state      <= RxIdle;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef DRIVE_CMD_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], rx};
            prev_q     <= sync_q[1];
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RxIdle: begin
                    if (prev_q && !sync_q[1]) begin
                        state <= RxStart;
                        cnt   <= '0;
                    end
                end
                RxStart: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync_q[1] ? RxIdle : RxData;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (cnt == CNT_BIT) begin
                        cnt     <= '0;
                        shreg   <= {sync_q[1], shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef DRIVE_CMD_PARITY_EN
                            state <= RxParity;
`else
                            state <= RxStop;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef DRIVE_CMD_PARITY_EN
                RxParity: begin
                    if (cnt == CNT_BIT) begin
                        cnt   <= '0;
                        par_q <= sync_q[1];
                        state <= RxStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                RxStop: begin
                    if (cnt == CNT_BIT) begin
                        cnt   <= '0;
                        state <= RxIdle;
`ifdef DRIVE_CMD_PARITY_EN
                        if (sync_q[1] && (par_q == ^shreg)) begin
`else
                        if (sync_q[1]) begin
`endif
                            data       <= shreg;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/drive_cmd_rx.sv
// Command front end: UART bytes -> held direction levels plus link-loss failsafe.
// Optional DRIVE_CMD_PARITY_EN selects 8E1 framing in the receiver.
module drive_cmd_rx
    import drive_cmd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned TIMEOUT_MS = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       fwd_out,
    output logic       bwd_out,
    output logic       left_out,
    output logic       right_out,
    output logic       failsafe_out,
    output logic       cmd_valid,
    output logic [7:0] last_cmd,
    output logic       frame_err
);

    localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
    localparam int unsigned WD_CYC  = (CLK_HZ / 1000) * TIMEOUT_MS;
    localparam int unsigned WD_W    = (WD_CYC > 1) ? $clog2(WD_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYC - 1);

    logic [7:0]      rx_data;
    logic            rx_valid;
    cmd_dec_t        dec;
    logic [3:0]      dir_q;
    logic [WD_W-1:0] wd_cnt;

    drive_cmd_rx_uart #(
        .BIT_CYC (BIT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (uart_rx),
        .data       (rx_data),
        .data_valid (rx_valid),
        .frame_err  (frame_err)
    );

    always_comb begin
        dec = decode_cmd(rx_data);
    end

    // An accepted command takes priority over a coincident watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= DIR_NONE;
            failsafe_out <= 1'b1;
            cmd_valid    <= 1'b0;
            last_cmd     <= 8'h00;
            wd_cnt       <= '0;
        end else begin
            cmd_valid <= 1'b0;
            if (rx_valid && dec.valid) begin
                dir_q        <= dec.dir;
                last_cmd     <= rx_data;
                cmd_valid    <= 1'b1;
                failsafe_out <= 1'b0;
                wd_cnt       <= '0;
            end else if (!failsafe_out) begin
                if (wd_cnt == WD_LAST) begin
                    failsafe_out <= 1'b1;
                    dir_q        <= DIR_NONE;
                    wd_cnt       <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign fwd_out   = dir_q[0];
    assign bwd_out   = dir_q[1];
    assign left_out  = dir_q[2];
    assign right_out = dir_q[3];

endmodule

// File: tb/tb_drive_cmd_rx.sv
// Scoreboard bench for drive_cmd_rx at BIT_CYC=10, WD_CYC=1000.
module tb_drive_cmd_rx;

    localparam int BIT = 10;
    localparam int WD  = 1000;

    typedef struct {
        logic [7:0] cmd;
        logic [3:0] dir;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic       fwd_out, bwd_out, left_out, right_out, failsafe_out;
    logic       cmd_valid, frame_err;
    logic [7:0] last_cmd;
    wire  [3:0] dirs = {right_out, left_out, bwd_out, fwd_out};

    int   tests;
    int   fails;
    int   n_valid;
    int   n_ferr;
    int   cyc;
    int   last_valid_cyc;
    exp_t exp_q[$];

    drive_cmd_rx #(
        .CLK_HZ     (1000000),
        .BAUD       (100000),
        .TIMEOUT_MS (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .fwd_out      (fwd_out),
        .bwd_out      (bwd_out),
        .left_out     (left_out),
        .right_out    (right_out),
        .failsafe_out (failsafe_out),
        .cmd_valid    (cmd_valid),
        .last_cmd     (last_cmd),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each cmd_valid pulse is matched against the oldest expected command.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) n_ferr = n_ferr + 1;
            if (cmd_valid) begin
                exp_t e;
                n_valid        = n_valid + 1;
                last_valid_cyc = cyc;
                tests          = tests + 1;
                if (exp_q.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL unexpected_cmd_valid: last_cmd=%h, none expected", last_cmd);
                end else begin
                    e = exp_q.pop_front();
                    if ({last_cmd, dirs, failsafe_out} !== {e.cmd, e.dir, 1'b0}) begin
                        fails = fails + 1;
                        $display("FAIL cmd_%h: got cmd=%h dir=%b fs=%b, want cmd=%h dir=%b fs=0",
                                 e.cmd, last_cmd, dirs, failsafe_out, e.cmd, e.dir);
                    end
                end
            end
        end
    end

    function automatic logic model_valid(input logic [7:0] b);
        return (b == 8'h46) || (b == 8'h42) || (b == 8'h4C) || (b == 8'h52) || (b == 8'h53);
    endfunction

    function automatic logic [3:0] model_dir(input logic [7:0] b);
        case (b)
            8'h46:   return 4'b0001;
            8'h42:   return 4'b0010;
            8'h4C:   return 4'b0100;
            8'h52:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        if (stop_bit && !bad_par && model_valid(b)) begin
            exp_t e;
            e.cmd = b;
            e.dir = model_dir(b);
            exp_q.push_back(e);
        end
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef DRIVE_CMD_PARITY_EN
        uart_rx = (^b) ^ bad_par;
        repeat (BIT) @(negedge clk);
`endif
        uart_rx = stop_bit;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        int v0;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        repeat (50) @(negedge clk);
        tests = tests + 4;
        if (failsafe_out !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL reset_failsafe: got %b want 1", failsafe_out);
        end
        if (dirs !== 4'b0000) begin
            fails = fails + 1;
            $display("FAIL reset_dirs: got %b want 0000", dirs);
        end
        if (last_cmd !== 8'h00 || frame_err !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL reset_last_cmd: got %h/%b want 00/0", last_cmd, frame_err);
        end
        if (n_valid != v0) begin
            fails = fails + 1;
            $display("FAIL reset_no_valid: got %0d pulses want 0", n_valid - v0);
        end
    endtask

    task automatic test_fwd_left();
        int v0;
        v0 = n_valid;
        send_byte(8'h46, 1'b1, 1'b0);
        tests = tests + 2;
        if (n_valid - v0 != 1) begin
            fails = fails + 1;
            $display("FAIL fwd_pulse_count: got %0d want 1", n_valid - v0);
        end
        if ({dirs, failsafe_out, last_cmd} !== {4'b0001, 1'b0, 8'h46}) begin
            fails = fails + 1;
            $display("FAIL fwd_held: got dir=%b fs=%b cmd=%h want 0001/0/46", dirs, failsafe_out,
                     last_cmd);
        end
        send_byte(8'h4C, 1'b1, 1'b0);
        tests = tests + 1;
        if (dirs !== 4'b0100) begin
            fails = fails + 1;
            $display("FAIL left_held: got %b want 0100", dirs);
        end
    endtask

    task automatic test_watchdog();
        int n;
        send_byte(8'h52, 1'b1, 1'b0);
        n = 0;
        while (!failsafe_out && n < 3 * WD) begin
            @(negedge clk);
            n++;
        end
        tests = tests + 2;
        if (cyc - last_valid_cyc != WD) begin
            fails = fails + 1;
            $display("FAIL wd_expiry_cycle: got %0d cycles want %0d", cyc - last_valid_cyc, WD);
        end
        if ({failsafe_out, dirs} !== 5'b10000) begin
            fails = fails + 1;
            $display("FAIL wd_expiry_outputs: got fs=%b dir=%b want 1/0000", failsafe_out, dirs);
        end
        send_byte(8'h53, 1'b1, 1'b0);
        tests = tests + 1;
        if ({failsafe_out, dirs} !== 5'b00000) begin
            fails = fails + 1;
            $display("FAIL stop_clears_fs: got fs=%b dir=%b want 0/0000", failsafe_out, dirs);
        end
    endtask

    task automatic test_ignored();
        int v0;
        int t46;
        int n;
        send_byte(8'h46, 1'b1, 1'b0);
        t46 = last_valid_cyc;
        v0  = n_valid;
        repeat (600 - 10 * BIT - 4) @(negedge clk);
        send_byte(8'h41, 1'b1, 1'b0);
        tests = tests + 2;
        if (n_valid != v0) begin
            fails = fails + 1;
            $display("FAIL ignored_no_valid: got %0d pulses want 0", n_valid - v0);
        end
        if ({dirs, last_cmd} !== {4'b0001, 8'h46}) begin
            fails = fails + 1;
            $display("FAIL ignored_no_change: got dir=%b cmd=%h want 0001/46", dirs, last_cmd);
        end
        n = 0;
        while (!failsafe_out && n < 3 * WD) begin
            @(negedge clk);
            n++;
        end
        tests = tests + 1;
        if (cyc - t46 != WD) begin
            fails = fails + 1;
            $display("FAIL ignored_no_refresh: got %0d cycles want %0d", cyc - t46, WD);
        end
        send_byte(8'h42, 1'b1, 1'b0);
        tests = tests + 1;
        if ({failsafe_out, dirs} !== 5'b00010) begin
            fails = fails + 1;
            $display("FAIL bwd_after_fs: got fs=%b dir=%b want 0/0010", failsafe_out, dirs);
        end
    endtask

    task automatic test_frame_err();
        int f0;
        int v0;
        f0 = n_ferr;
        v0 = n_valid;
        send_byte(8'h42, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        tests = tests + 2;
        if (n_ferr - f0 != 1 || n_valid != v0) begin
            fails = fails + 1;
            $display("FAIL stop_bit_err: got ferr=%0d valid=%0d want 1/0", n_ferr - f0,
                     n_valid - v0);
        end
        if ({dirs, last_cmd} !== {4'b0010, 8'h42}) begin
            fails = fails + 1;
            $display("FAIL stop_bit_hold: got dir=%b cmd=%h want 0010/42", dirs, last_cmd);
        end
        f0 = n_ferr;
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        tests = tests + 1;
        if (n_ferr != f0 || n_valid != v0) begin
            fails = fails + 1;
            $display("FAIL glitch: got ferr=%0d valid=%0d want 0/0", n_ferr - f0, n_valid - v0);
        end
`ifdef DRIVE_CMD_PARITY_EN
        f0 = n_ferr;
        send_byte(8'h46, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        tests = tests + 1;
        if (n_ferr - f0 != 1 || n_valid != v0 || dirs !== 4'b0010) begin
            fails = fails + 1;
            $display("FAIL parity_err: got ferr=%0d valid=%0d dir=%b want 1/0/0010",
                     n_ferr - f0, n_valid - v0, dirs);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        seq = '{8'h46, 8'h42, 8'h4C, 8'h52};
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i], 1'b1, 1'b0);
        end
        tests = tests + 1;
        if (dirs !== 4'b1000) begin
            fails = fails + 1;
            $display("FAIL b2b_final: got %b want 1000", dirs);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int v0;
        int f0;
        b = 8'h46;
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = b[4];
        repeat (BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        f0 = n_ferr;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        tests = tests + 2;
        if (n_valid != v0 || n_ferr != f0) begin
            fails = fails + 1;
            $display("FAIL reset_partial: got valid=%0d ferr=%0d want 0/0", n_valid - v0,
                     n_ferr - f0);
        end
        if ({failsafe_out, dirs, last_cmd} !== {1'b1, 4'b0000, 8'h00}) begin
            fails = fails + 1;
            $display("FAIL reset_mid_state: got fs=%b dir=%b cmd=%h want 1/0000/00",
                     failsafe_out, dirs, last_cmd);
        end
        send_byte(8'h42, 1'b1, 1'b0);
        tests = tests + 1;
        if ({failsafe_out, dirs, n_valid - v0} !== {1'b0, 4'b0010, 32'd1}) begin
            fails = fails + 1;
            $display("FAIL reset_then_bwd: got fs=%b dir=%b valid=%0d want 0/0010/1",
                     failsafe_out, dirs, n_valid - v0);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        n_valid        = 0;
        n_ferr         = 0;
        cyc            = 0;
        last_valid_cyc = 0;
        rst_n          = 1'b0;
        uart_rx        = 1'b1;
        test_reset();
        test_fwd_left();
        test_watchdog();
        test_ignored();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
